// File: rtl/lieat_ifu_icache_nway_pkg.sv
// Shared definitions for the N-way instruction cache: the default datapath width,
// the one-hot FSM encoding, and helpers that derive the address field widths.
package lieat_ifu_icache_nway_pkg;

  localparam int ICACHE_XLEN = 32;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001,
    ST_AR     = 4'b0010,
    ST_REFILL = 4'b0100,
    ST_RSP    = 4'b1000
  } icache_state_e;

  // The byte offset covers the 32-bit word plus the word-within-line index.
  function automatic int ofs_bits(input int line_words);
    return 2 + $clog2(line_words);
  endfunction

  function automatic int idx_bits(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_bits(input int xlen, input int sets, input int line_words);
    return xlen - idx_bits(sets) - ofs_bits(line_words);
  endfunction

endpackage

// File: rtl/lieat_ifu_icache_nway_plru.sv
// Tree pseudo-LRU helper for one cache set. Purely combinational; the per-set
// bits are stored by the parent. Bits are heap-ordered (bit n-1 is node n,
// root is node 1). A node bit of 1 means the victim lies in the right subtree.
module lieat_icache_plru #(
  parameter int WAYS = 4
) (
  input  logic [WAYS-2:0]         i_plru,
  input  logic [$clog2(WAYS)-1:0] i_way,
  input  logic                    i_en,
  output logic [WAYS-2:0]         o_plru_next,
  output logic [$clog2(WAYS)-1:0] o_victim
);

  localparam int LVL = $clog2(WAYS);

  // Follow the node bits from the root down to a leaf to pick the victim.
  always_comb begin
    int   v_node;
    logic v_bit;
    v_node = 1;
    for (int l = 0; l < LVL; l++) begin
      v_bit = 1'b0;
      for (int n = 1; n < WAYS; n++)
        if (n == v_node) v_bit = i_plru[n-1];
      v_node = 2 * v_node + int'(v_bit);
    end
    o_victim = LVL'(v_node - WAYS);
  end

  // On an access, point every node on the path away from the accessed way.
  always_comb begin
    int u_node;
    o_plru_next = i_plru;
    u_node      = 1;
    if (i_en) begin
      for (int l = 0; l < LVL; l++) begin
        for (int n = 1; n < WAYS; n++)
          if (n == u_node) o_plru_next[n-1] = ~i_way[LVL-1-l];
        u_node = 2 * u_node + int'(i_way[LVL-1-l]);
      end
    end
  end

endmodule

// File: rtl/lieat_ifu_icache_nway.sv
// N-way set-associative instruction cache between the fetch stage and an
// AXI read port. Tags, valid and PLRU bits are flops so lookup completes in
// the accept cycle; misses refill a whole line with one INCR burst.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | ready for a fetch; lookup happens in the accept cycle
//   ST_AR     | miss pending; read address presented until arready
//   ST_REFILL | collecting LINE_WORDS beats into the victim way
//   ST_RSP    | instruction presented until the consumer takes it
module lieat_ifu_icache_nway
  import lieat_ifu_icache_nway_pkg::*;
#(
  parameter int XLEN       = ICACHE_XLEN,
  parameter int WAYS       = 4,
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            i_flush_req,
  input  logic            i_fencei_req,
  input  logic            i_ifetch_req_valid,
  output logic            o_ifetch_req_ready,
  input  logic [XLEN-1:0] i_ifetch_req_pc,
  output logic            o_ifetch_rsp_valid,
  input  logic            i_ifetch_rsp_ready,
  output logic [XLEN-1:0] o_ifetch_rsp_pc,
  output logic [XLEN-1:0] o_ifetch_rsp_inst,
  output logic [XLEN-1:0] o_axi_araddr,
  output logic [7:0]      o_axi_arlen,
  output logic            o_axi_arvalid,
  input  logic            i_axi_arready,
  input  logic [31:0]     i_axi_rdata,
  input  logic            i_axi_rvalid,
  input  logic            i_axi_rlast,
  output logic            o_axi_rready
);

  localparam int OFS = ofs_bits(LINE_WORDS);
  localparam int IDX = idx_bits(SETS);
  localparam int TAG = tag_bits(XLEN, SETS, LINE_WORDS);
  localparam int WW  = $clog2(WAYS);
  localparam int CW  = $clog2(LINE_WORDS);
  localparam logic [CW-1:0] CNT_LAST = CW'(LINE_WORDS - 1);

  icache_state_e   r_state, w_state_next;
  logic [TAG-1:0]  r_tag   [SETS][WAYS];
  logic [WAYS-1:0] r_valid [SETS];
  logic [WAYS-2:0] r_plru  [SETS];
  logic [31:0]     r_data  [SETS][WAYS][LINE_WORDS];
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_inst;
  logic [WW-1:0]   r_way;
  logic [CW-1:0]   r_cnt;
  logic            r_kill;
  logic            r_inhibit;

  logic [TAG-1:0]  w_req_tag, w_fill_tag;
  logic [IDX-1:0]  w_req_idx, w_fill_idx, w_plru_idx;
  logic [CW-1:0]   w_req_word, w_fill_word;
  logic            w_hit;
  logic [WW-1:0]   w_hit_way, w_victim, w_plru_way;
  logic [WAYS-2:0] w_plru_next;
  logic            w_accept, w_beat, w_last, w_drop, w_plru_en;

  assign w_req_tag   = i_ifetch_req_pc[XLEN-1 -: TAG];
  assign w_req_idx   = i_ifetch_req_pc[OFS +: IDX];
  assign w_req_word  = i_ifetch_req_pc[2 +: CW];
  assign w_fill_tag  = r_pc[XLEN-1 -: TAG];
  assign w_fill_idx  = r_pc[OFS +: IDX];
  assign w_fill_word = r_pc[2 +: CW];

  assign w_accept = i_ifetch_req_valid & o_ifetch_req_ready;
  assign w_beat   = (r_state == ST_REFILL) & i_axi_rvalid;
  assign w_last   = w_beat & (r_cnt == CNT_LAST);
  assign w_drop   = r_kill | i_flush_req;

  // Tag match across all ways; a fence.i in the same cycle forces a miss so
  // the request never sees a line that is being invalidated.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[w_req_idx][w] && (r_tag[w_req_idx][w] == w_req_tag)) begin
        w_hit     = ~i_fencei_req;
        w_hit_way = WW'(w);
      end
    end
  end

  // One PLRU helper serves the lookup set, or the fill set while refilling.
  assign w_plru_idx = (r_state == ST_REFILL) ? w_fill_idx : w_req_idx;
  assign w_plru_way = (r_state == ST_REFILL) ? r_way : w_hit_way;
  assign w_plru_en  = (w_accept & w_hit) | w_last;

  lieat_icache_plru #(.WAYS(WAYS)) u_plru (
    .i_plru      (r_plru[w_plru_idx]),
    .i_way       (w_plru_way),
    .i_en        (w_plru_en),
    .o_plru_next (w_plru_next),
    .o_victim    (w_victim)
  );

  // Next-state and handshake decode.
  always_comb begin
    w_state_next       = r_state;
    o_ifetch_req_ready = 1'b0;
    o_ifetch_rsp_valid = 1'b0;
    o_axi_arvalid      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        o_ifetch_req_ready = 1'b1;
        if (i_ifetch_req_valid) w_state_next = w_hit ? ST_RSP : ST_AR;
      end
      ST_AR: begin
        o_axi_arvalid = 1'b1;
        if (i_axi_arready) w_state_next = ST_REFILL;
      end
      ST_REFILL: begin
        if (w_last) w_state_next = w_drop ? ST_IDLE : ST_RSP;
      end
      ST_RSP: begin
        o_ifetch_rsp_valid = ~i_flush_req;
        o_ifetch_req_ready = i_ifetch_rsp_ready | i_flush_req;
        if (i_ifetch_req_valid && (i_ifetch_rsp_ready || i_flush_req))
          w_state_next = w_hit ? ST_RSP : ST_AR;
        else if (i_ifetch_rsp_ready || i_flush_req)
          w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Control state, response capture, valid and PLRU bookkeeping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_pc      <= '0;
      r_inst    <= '0;
      r_way     <= '0;
      r_cnt     <= '0;
      r_kill    <= 1'b0;
      r_inhibit <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_plru[s]  <= '0;
      end
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_pc      <= i_ifetch_req_pc;
        r_cnt     <= '0;
        r_kill    <= 1'b0;
        r_inhibit <= 1'b0;
        if (w_hit) begin
          r_way  <= w_hit_way;
          r_inst <= r_data[w_req_idx][w_hit_way][w_req_word];
        end else begin
          r_way <= w_victim;
        end
      end
      if ((r_state == ST_AR) || (r_state == ST_REFILL)) begin
        if (i_flush_req)  r_kill    <= 1'b1;
        if (i_fencei_req) r_inhibit <= 1'b1;
      end
      if (w_beat) begin
        r_cnt <= r_cnt + CW'(1);
        if (r_cnt == w_fill_word) r_inst <= i_axi_rdata;
      end
      if (w_last) r_valid[w_fill_idx][r_way] <= ~(r_inhibit | i_fencei_req);
      if (w_plru_en) r_plru[w_plru_idx] <= w_plru_next;
      if (i_fencei_req) begin
        for (int s = 0; s < SETS; s++) begin
          r_valid[s] <= '0;
          r_plru[s]  <= '0;
        end
      end
    end
  end

  // Line data and tags need no reset; valid bits qualify them.
  always_ff @(posedge clock) begin
    if (w_beat) r_data[w_fill_idx][r_way][r_cnt] <= i_axi_rdata;
    if (w_last) r_tag[w_fill_idx][r_way] <= w_fill_tag;
  end

  // Burst completion follows the beat counter; rlast is only cross-checked.
  always @(posedge clock) begin
    if (!reset && w_beat) assert (i_axi_rlast == (r_cnt == CNT_LAST));
  end

  assign o_ifetch_rsp_pc   = r_pc;
  assign o_ifetch_rsp_inst = r_inst;
  assign o_axi_araddr      = {w_fill_tag, w_fill_idx, {OFS{1'b0}}};
  assign o_axi_arlen       = 8'(LINE_WORDS - 1);
  assign o_axi_rready      = 1'b1;

endmodule
